// File: rtl/mips_pkg.sv
// Shared MIPS front-end types and constants.
// Opcodes, fetch FSM states and the fetched-word bundle.
package mips_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_HALT  = 6'b111111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    RUN,
    HALTED
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } fetch_word_t;

  function automatic logic [5:0] opcode_of(
    input logic [31:0] w
  );
    return w[31:26];
  endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetch response
// that arrives while the decoder is stalled.
module fetch_skid_buf
  import mips_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        clear,
  input  logic        load,
  input  logic        drain,
  input  fetch_word_t din,
  output logic        valid,
  output fetch_word_t dout
);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (clear) begin
      valid <= 1'b0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (drain) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: PC, imem request, IF/ID
// register, stall skid, redirect flush and HALT stop.
module instr_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [5:0]  HALT_OP  = OP_HALT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_en,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        halted
);

  fetch_state_e state;
  logic [31:0]  pc;
  logic [31:0]  req_pc;
  logic         req_valid;
  fetch_word_t  ifid;
  fetch_word_t  rsp;
  fetch_word_t  skid_q;
  fetch_word_t  ld_word;
  logic         skid_valid;
  logic         run;
  logic         flush;
  logic         live;
  logic         take_skid;
  logic         take_rsp;
  logic         to_skid;
  logic         ld;
  logic         halt_hit;

  assign run   = (state == RUN);
  assign flush = run & redirect;
  assign live  = run & ~redirect;

  assign imem_en   = run & ~stall & ~redirect & ~rst;
  assign imem_addr = pc;

  assign rsp = '{instr: imem_rdata, pc: req_pc};

  // skid only fills while stalled, so it always
  // holds the older word when both could load
  assign take_skid = live & ~stall & skid_valid;
  assign take_rsp  = live & ~stall & ~skid_valid
                   & req_valid;
  assign to_skid   = live & stall & req_valid;
  assign ld        = take_skid | take_rsp;
  assign ld_word   = skid_valid ? skid_q : rsp;
  assign halt_hit  = ld
                   & (opcode_of(ld_word.instr) == HALT_OP);

  fetch_skid_buf u_skid (
    .clk   (clk),
    .rst   (rst),
    .clear (flush | ~run),
    .load  (to_skid),
    .drain (take_skid),
    .din   (rsp),
    .valid (skid_valid),
    .dout  (skid_q)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= RUN;
      pc        <= RESET_PC;
      req_valid <= 1'b0;
      req_pc    <= '0;
      if_valid  <= 1'b0;
      ifid      <= '0;
      halted    <= 1'b0;
    end else begin
      req_valid <= imem_en;
      if (imem_en) begin
        pc     <= pc + 32'd4;
        req_pc <= pc;
      end else if (flush) begin
        pc <= redirect_pc & ~32'd3;
      end
      unique case (1'b1)
        flush: if_valid <= 1'b0;
        ld: begin
          if_valid <= 1'b1;
          ifid     <= ld_word;
        end
        default: if (!stall) if_valid <= 1'b0;
      endcase
      if (halt_hit) begin
        state  <= HALTED;
        halted <= 1'b1;
      end
    end
  end

  assign if_instr    = ifid.instr;
  assign if_pc       = ifid.pc;
  assign if_pc_plus4 = ifid.pc + 32'd4;

endmodule
